clock_mode_ctrl: RTL and testbench

Front-panel control stage feeding the processor clock divider. It synchronises and debounces the board push-buttons and drives the divider's freq[1:0], reset and Halt inputs. It also implements a run/single-step mode: one step press releases the divider for exactly one divided-clock period, using clk_out fed back from the divider. Runs entirely on the board clock.

---
 rtl/clock_mode_if.sv | 21 ++
 rtl/clock_mode_ctrl.sv | 99 +++++++++
 tb/tb_clock_mode_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/clock_mode_if.sv
// clock_mode_if: board buttons, processor halt request, divider feedback and divider controls
interface clock_mode_if;
    logic       btn_reset;
    logic       btn_mode;
    logic       btn_run;
    logic       btn_step;
    logic       cpu_halt;
    logic       clk_out_fb;
    logic [1:0] freq;
    logic       sys_reset;
    logic       halt;
    logic       step_mode;
    modport master (
        output btn_reset, btn_mode, btn_run, btn_step, cpu_halt, clk_out_fb,
        input  freq, sys_reset, halt, step_mode
    );
    modport slave (
        input  btn_reset, btn_mode, btn_run, btn_step, cpu_halt, clk_out_fb,
        output freq, sys_reset, halt, step_mode
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: debounced front-panel buttons driving the clock divider's freq, reset and halt, with run/single-step
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_STRETCH     = 16
) (
    input logic         clk,
    input logic         reset,
    clock_mode_if.slave cm
);
    localparam int CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW     = $clog2(RST_STRETCH + 1);
    localparam int B_RST  = 0;
    localparam int B_MODE = 1;
    localparam int B_RUN  = 2;
    localparam int B_STEP = 3;

    typedef enum logic [1:0] {RUN, STOPPED, STEP_FALL, STEP_RISE} state_e;

    logic [3:0]    btn_raw, sync1_q, sync2_q, press;
    logic [SW-1:0] str_q, str_d;
    logic [1:0]    freq_q, freq_d;
    logic          step_mode_q, step_mode_d;
    logic          sys_reset_q, halt_q, halt_d;
    state_e        state_q, state_d;

    assign btn_raw = {cm.btn_step, cm.btn_run, cm.btn_mode, cm.btn_reset};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CW-1:0] cnt_q;
        logic          stable_q, prev_q, flip;
        assign flip = sync2_q[i] != stable_q && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q    <= '0;
                stable_q <= 1'b0;
                prev_q   <= 1'b0;
            end else begin
                cnt_q    <= (sync2_q[i] == stable_q || flip) ? '0 : cnt_q + 1'b1;
                stable_q <= stable_q ^ flip;
                prev_q   <= stable_q;
            end
        end
        assign press[i] = stable_q & ~prev_q;
    end

    always_comb begin
        freq_d      = freq_q + {1'b0, press[B_MODE]};
        step_mode_d = step_mode_q ^ press[B_RUN];
        str_d       = press[B_RST] ? SW'(RST_STRETCH) : (str_q != '0 ? str_q - 1'b1 : str_q);
    end

    // a run press in the same cycle as a step press cancels the step
    always_comb begin
        state_d = state_q;
        if (sys_reset_q || !step_mode_q)
            state_d = step_mode_q ? STOPPED : RUN;
        else
            case (state_q)
                RUN:       state_d = STOPPED;
                STOPPED:   state_d = (press[B_STEP] && !press[B_RUN]) ? STEP_FALL : STOPPED;
                STEP_FALL: state_d = cm.clk_out_fb ? STEP_FALL : STEP_RISE;
                default:   state_d = cm.clk_out_fb ? STOPPED : STEP_RISE;
            endcase
        halt_d = cm.cpu_halt || (step_mode_q && (state_q == RUN || state_q == STOPPED));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            freq_q      <= 2'b01;
            step_mode_q <= 1'b0;
            str_q       <= SW'(RST_STRETCH);
            sys_reset_q <= 1'b1;
            state_q     <= RUN;
            halt_q      <= 1'b0;
        end else begin
            freq_q      <= freq_d;
            step_mode_q <= step_mode_d;
            str_q       <= str_d;
            sys_reset_q <= str_d != '0;
            state_q     <= state_d;
            halt_q      <= halt_d;
        end
    end

    assign cm.freq      = freq_q;
    assign cm.step_mode = step_mode_q;
    assign cm.sys_reset = sys_reset_q;
    assign cm.halt      = halt_q;
endmodule

// File: tb/tb_clock_mode_ctrl.sv
// tb_clock_mode_ctrl: vector table, hand-written step/reset sequences and random stimulus against a reference model
module tb_clock_mode_ctrl;
    localparam int DC = 4;
    localparam int RS = 16;
    localparam int FREE = 0, PARKED = 1, AWAIT_LOW = 2, AWAIT_HIGH = 3;

    typedef struct {
        logic [3:0] btn;
        logic       chalt;
        int         n;
        logic [4:0] exp;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    clock_mode_if cm();
    clock_mode_ctrl #(.DEBOUNCE_CYCLES(DC), .RST_STRETCH(RS)) dut (
        .clk(clk), .reset(reset), .cm(cm)
    );

    always #5 clk = ~clk;

    // reference model: buttons seen two edges late, accepted after DC differing samples
    logic [3:0] h1, h2, stab, prev;
    int         m_run[4];
    int         m_freq, m_left, m_phase;
    logic       m_sm, m_sys, m_halt;

    task automatic model_edge();
        logic [3:0] raw, pr;
        logic       hn;
        raw = {cm.btn_step, cm.btn_run, cm.btn_mode, cm.btn_reset};
        if (reset) begin
            h1 = '0; h2 = '0; stab = '0; prev = '0;
            m_run = '{default: 0};
            m_freq = 1; m_sm = 1'b0; m_left = RS; m_sys = 1'b1; m_phase = FREE; m_halt = 1'b0;
            return;
        end
        pr = stab & ~prev;
        hn = cm.cpu_halt || (m_sm && (m_phase == FREE || m_phase == PARKED));
        if (m_sys || !m_sm) m_phase = m_sm ? PARKED : FREE;
        else if (m_phase == FREE) m_phase = PARKED;
        else if (m_phase == PARKED) begin if (pr[3] && !pr[2]) m_phase = AWAIT_LOW; end
        else if (m_phase == AWAIT_LOW) begin if (!cm.clk_out_fb) m_phase = AWAIT_HIGH; end
        else if (cm.clk_out_fb) m_phase = PARKED;
        m_freq = (m_freq + int'(pr[1])) % 4;
        m_sm   = m_sm ^ pr[2];
        m_left = pr[0] ? RS : (m_left > 0 ? m_left - 1 : 0);
        m_sys  = m_left != 0;
        prev   = stab;
        for (int b = 0; b < 4; b++) begin
            if (h2[b] != stab[b]) begin
                m_run[b]++;
                if (m_run[b] == DC) begin
                    stab[b] = ~stab[b];
                    m_run[b] = 0;
                end
            end else m_run[b] = 0;
        end
        h2 = h1;
        h1 = raw;
        m_halt = hn;
    endtask

    function automatic int outs();
        return int'({cm.freq, cm.step_mode, cm.halt, cm.sys_reset});
    endfunction

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    task automatic tick();
        int want;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        want = int'({2'(m_freq), m_sm, m_halt, m_sys});
        checks++;
        if (outs() != want) begin
            failures++;
            $display("FAIL model @%0t: got {freq,step_mode,halt,sys_reset}=%05b expected %05b",
                     $time, 5'(outs()), 5'(want));
        end
    endtask

    task automatic set_btn(logic [3:0] b);
        {cm.btn_step, cm.btn_run, cm.btn_mode, cm.btn_reset} = b;
    endtask

    task automatic apply(vec_t v);
        set_btn(v.btn);
        cm.cpu_halt = v.chalt;
        repeat (v.n) tick();
        chk(v.name, outs(), int'(v.exp));
    endtask

    task automatic press(logic [3:0] b);
        set_btn(b);
        repeat (5) tick();
        set_btn(4'b0000);
        repeat (6) tick();
    endtask

    initial begin
        vec_t tbl[$];
        int   n;
        int   rem[4];
        logic [3:0] lvl;
        reset = 1'b1;
        set_btn(4'b0000);
        cm.cpu_halt = 1'b0;
        cm.clk_out_fb = 1'b1;
        tick();
        chk("reset_state", outs(), 5'b01001);
        reset = 1'b0;
        n = 0;
        while (cm.sys_reset && n < 100) begin
            n++;
            tick();
        end
        chk("reset_stretch_len", n, RS);

        // {btn = step,run,mode,reset}, cpu_halt, ticks, {freq,step_mode,halt,sys_reset}
        tbl.push_back('{4'b0010, 1'b0, 3,  5'b01000, "glitch_3"});
        tbl.push_back('{4'b0000, 1'b0, 8,  5'b01000, "glitch_idle"});
        tbl.push_back('{4'b0010, 1'b0, 10, 5'b10000, "hold_10"});
        tbl.push_back('{4'b0000, 1'b0, 8,  5'b10000, "hold_release"});
        tbl.push_back('{4'b0010, 1'b0, 5,  5'b10000, "p1_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b11000, "p1_up"});
        tbl.push_back('{4'b0010, 1'b0, 5,  5'b11000, "p2_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b00000, "p2_up"});
        tbl.push_back('{4'b0010, 1'b0, 5,  5'b00000, "p3_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b01000, "p3_up"});
        tbl.push_back('{4'b0010, 1'b0, 5,  5'b01000, "p4_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b10000, "p4_up"});
        tbl.push_back('{4'b0010, 1'b0, 5,  5'b10000, "p5_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b11000, "p5_up"});
        tbl.push_back('{4'b0000, 1'b1, 1,  5'b11010, "cpu_halt_rise"});
        tbl.push_back('{4'b0000, 1'b0, 1,  5'b11000, "cpu_halt_fall"});
        tbl.push_back('{4'b0100, 1'b0, 5,  5'b11000, "run_down"});
        tbl.push_back('{4'b0000, 1'b0, 6,  5'b11110, "run_up"});
        foreach (tbl[i]) apply(tbl[i]);

        n = 0;
        for (int i = 0; i < 40; i++) begin
            cm.btn_reset = i < 5;
            tick();
            n += int'(cm.sys_reset);
        end
        chk("btn_reset_len", n, RS);
        chk("btn_reset_keeps", outs(), 5'b11110);
        // second press lands when the stretch counter is at 5, so 12 cycles precede the fresh window
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cm.btn_reset = (i < 5) || (i >= 12 && i < 17);
            tick();
            n += int'(cm.sys_reset);
        end
        chk("btn_reset_retrigger_len", n, 12 + RS);
        chk("retrigger_keeps", outs(), 5'b11110);

        cm.btn_step = 1'b1;
        repeat (5) tick();
        cm.btn_step = 1'b0;
        repeat (2) tick();
        chk("step_halt_still_high", cm.halt, 1);
        tick();
        chk("step_halt_released", cm.halt, 0);
        repeat (2) tick();
        chk("step_wait_fall", cm.halt, 0);
        cm.clk_out_fb = 1'b0;
        tick();
        chk("step_after_fall", cm.halt, 0);
        cm.btn_step = 1'b1;
        repeat (5) tick();
        cm.btn_step = 1'b0;
        repeat (4) tick();
        chk("step_press_in_rise", cm.halt, 0);
        cm.clk_out_fb = 1'b1;
        tick();
        chk("rise_same_cycle", cm.halt, 0);
        tick();
        chk("rise_halt", cm.halt, 1);
        for (int i = 0; i < 12; i++) begin
            cm.clk_out_fb = i[0];
            tick();
            chk("parked_no_queued_step", cm.halt, 1);
        end
        cm.clk_out_fb = 1'b1;

        cm.btn_step = 1'b1;
        repeat (5) tick();
        cm.btn_step = 1'b0;
        repeat (3) tick();
        chk("fall_entered", cm.halt, 0);
        press(4'b0100);
        chk("run_aborts_step", outs(), 5'b11000);
        press(4'b0100);
        chk("step_mode_again", outs(), 5'b11110);
        press(4'b1100);
        chk("run_and_step", outs(), 5'b11000);

        for (int b = 0; b < 4; b++) rem[b] = 0;
        lvl = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int b = 0; b < 4; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    rem[b] = int'($urandom_range(1, 10));
                end
                rem[b]--;
            end
            set_btn(lvl);
            reset = $urandom_range(0, 399) == 0;
            cm.cpu_halt = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 2) == 0) cm.clk_out_fb = ~cm.clk_out_fb;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
